cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Driving end of the common data bus (CDB).
- Execution units each present one finished result (valid/ready handshake plus ROB tag and data). The block grants one unit per cycle by round-robin and broadcasts the winner's tag/data on a registered CDB one cycle later.
- Reservation stations, the ROB and register-file wakeup logic consume the broadcast via tag match (valid && tag==_tag).
- Sits between the unit result ports and every CDB listener in the core.

Parameters:
- N_UNITS, 4, number of requesting execution units (≥2).
- ROB_WIDTH, 4, ROB tag width; equals the global ROB_WIDTH.
- DATA_WIDTH, 32, result data width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  misprediction flush; cancels pending and next broadcast.
- req_valid  input  N_UNITS  per-unit result valid.
- req_ready  output  N_UNITS  per-unit grant; transfer when valid&&ready.
- req_tag  input  N_UNITS*ROB_WIDTH  per-unit ROB tag; unit i at [i*ROB_WIDTH +: ROB_WIDTH].
- req_data  input  N_UNITS*DATA_WIDTH  per-unit result data; unit i at [i*DATA_WIDTH +: DATA_WIDTH].
- cdb_valid  output  1  broadcast valid.
- cdb_tag  output  ROB_WIDTH  broadcast ROB tag.
- cdb_data  output  DATA_WIDTH  broadcast data.
- cdb_src  output  log2(N_UNITS)  index of the unit whose result is on the bus (debug/perf).

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge clk.
  - Reset is synchronous and active-high. In the reset cycle: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, priority pointer ptr=0, req_ready=0.
- Handshake rules for units:
  - Once req_valid[i] is raised, the unit holds it and keeps tag/data stable until it sees req_ready[i]=1 at a clock edge.
  - req_valid[i] does not depend on req_ready[i].
- Grant logic (combinational):
  - When flush=0 and reset=0, the winner is the first i with req_valid[i]=1, scanning from ptr upward with wrap modulo N_UNITS.
  - req_ready is one-hot at the winner and 0 elsewhere.
  - No valid request gives req_ready=0.
  - req_ready depends only on req_valid, ptr, flush and reset.
- Pointer update:
  - On a grant to unit w, ptr <= (w+1) mod N_UNITS.
  - Without a grant, ptr holds.
  - Wrap: w=N_UNITS-1 gives ptr=0.
- Broadcast register:
  - On a grant: cdb_valid<=1, cdb_tag<=req_tag[w], cdb_data<=req_data[w], cdb_src<=w.
  - Otherwise cdb_valid<=0 and tag/data/src hold their last values.
  - Latency: handshake in cycle t gives broadcast visible in cycle t+1 for exactly one cycle.
- Throughput: one result per cycle, no bubbles between back-to-back grants.
- Fairness: a continuously valid requester is granted within N_UNITS cycles.
- Flush:
  - flush=1 forces req_ready=0, so no transfer happens and units keep their requests.
  - Next cycle cdb_valid=0; ptr holds.
  - A broadcast already on the bus during the flush cycle is still visible that cycle; listeners discard it.
- Reset mid-operation: identical to power-on reset. Any registered broadcast is dropped, and units with req_valid held are re-arbitrated from ptr=0 after reset deasserts.
- Simultaneous events:
  - reset has priority over flush; flush has priority over grant.
  - All units valid at once: exactly one grant per cycle, rotating.
- No storage beyond the output register and ptr. Back-pressure to units is only via req_ready.

Test Plan:
- Reset, then req_valid=4'b0010, tag=5, data=32'hDEADBEEF on unit 1 -> req_ready=4'b0010 same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=DEADBEEF, cdb_src=1; following cycle cdb_valid=0; ptr=2.
- All four units valid continuously from ptr=0 with tags 0..3 -> grants 0,1,2,3,0 on consecutive cycles; cdb_tag sequence 0,1,2,3,0 with no idle cycle.
- ptr=3, req_valid=4'b1001 -> unit 3 granted first, then unit 0 (wrap); ptr ends at 1.
- Unit 2 valid with tag 7, flush=1 for 2 cycles -> req_ready=0 and cdb_valid=0 throughout; flush drops -> unit 2 granted; cdb_tag=7 next cycle.
- Grant to unit 0 at cycle t, reset=1 at t+1 -> cdb_valid=0 at t+2, ptr=0; unit 1 still valid -> granted the first cycle after reset falls.
- Random valid patterns over 10k cycles, each request holding until ready -> scoreboard: every accepted (tag,data) appears on CDB exactly once, one cycle after its handshake; no request waits more than N_UNITS grant cycles.

Source files
------------

// File: rtl/cdb_arbiter.sv
// ============================================================================
// cdb_arbiter
// ----------------------------------------------------------------------------
// Driving end of the common data bus (CDB). Each execution unit presents one
// finished result through a valid/ready handshake together with its ROB tag
// and result data. Every cycle at most one unit is granted, chosen round-robin
// starting at a rotating priority pointer. The winner's tag/data are captured
// into a broadcast register and appear on the CDB in the following cycle for
// exactly one cycle. Listeners (reservation stations, ROB, register-file
// wakeup) pick results up by matching cdb_valid && cdb_tag.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-high reset
//   flush      : misprediction flush; blocks any grant this cycle so the
//                next cycle carries no broadcast
//   req_valid  : per-unit result valid              [N_UNITS]
//   req_ready  : per-unit grant (one-hot or zero)   [N_UNITS]
//   req_tag    : per-unit ROB tag, unit i at [i*ROB_WIDTH +: ROB_WIDTH]
//   req_data   : per-unit data,    unit i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cdb_valid  : broadcast valid
//   cdb_tag    : broadcast ROB tag
//   cdb_data   : broadcast result data
//   cdb_src    : index of the unit whose result is on the bus
// ============================================================================
module cdb_arbiter #(
    parameter int N_UNITS    = 4,
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    localparam int SRC_WIDTH = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [N_UNITS-1:0]               req_valid,
    output logic [N_UNITS-1:0]               req_ready,
    input  logic [N_UNITS*ROB_WIDTH-1:0]     req_tag,
    input  logic [N_UNITS*DATA_WIDTH-1:0]    req_data,
    output logic                             cdb_valid,
    output logic [ROB_WIDTH-1:0]             cdb_tag,
    output logic [DATA_WIDTH-1:0]            cdb_data,
    output logic [SRC_WIDTH-1:0]             cdb_src
);

    // ------------------------------------------------------------------------
    // State: priority pointer and the broadcast register
    // ------------------------------------------------------------------------
    logic [SRC_WIDTH-1:0]  r_ptr;
    logic                  r_cdb_valid;
    logic [ROB_WIDTH-1:0]  r_cdb_tag;
    logic [DATA_WIDTH-1:0] r_cdb_data;
    logic [SRC_WIDTH-1:0]  r_cdb_src;

    // ------------------------------------------------------------------------
    // Unpack the flat per-unit buses into arrays for readable muxing
    // ------------------------------------------------------------------------
    logic [ROB_WIDTH-1:0]  w_tag_arr  [N_UNITS];
    logic [DATA_WIDTH-1:0] w_data_arr [N_UNITS];

    generate
        for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_unpack
            assign w_tag_arr[gi]  = req_tag[gi*ROB_WIDTH +: ROB_WIDTH];
            assign w_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Rotated view of the requests: slot k holds unit (ptr + k) mod N_UNITS.
    // Slot 0 therefore has the highest priority. The sum is one bit wider
    // than the index so ptr + k (at most 2*N_UNITS-2) never overflows.
    // ------------------------------------------------------------------------
    logic [SRC_WIDTH-1:0] w_rot_idx [N_UNITS];
    logic [N_UNITS-1:0]   w_req_rot;

    generate
        for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_rotate
            logic [SRC_WIDTH:0] w_sum;
            assign w_sum = {1'b0, r_ptr} + (SRC_WIDTH+1)'(gi);
            assign w_rot_idx[gi] = (w_sum >= (SRC_WIDTH+1)'(N_UNITS))
                                 ? SRC_WIDTH'(w_sum - (SRC_WIDTH+1)'(N_UNITS))
                                 : SRC_WIDTH'(w_sum);
            assign w_req_rot[gi] = req_valid[w_rot_idx[gi]];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Winner search: first valid slot in rotated order
    // ------------------------------------------------------------------------
    logic                 w_found;
    logic [SRC_WIDTH-1:0] w_win;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            if (!w_found && w_req_rot[k]) begin
                w_found = 1'b1;
                w_win   = w_rot_idx[k];
            end
        end
    end

    // Reset outranks flush, flush outranks a grant.
    logic w_grant;
    assign w_grant = w_found && !reset && !flush;

    generate
        for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_ready
            assign req_ready[gi] = w_grant && (w_win == SRC_WIDTH'(gi));
        end
    endgenerate

    // Pointer moves to the unit just after the winner, wrapping at the top.
    logic [SRC_WIDTH-1:0] w_ptr_next;
    assign w_ptr_next = (w_win == SRC_WIDTH'(N_UNITS-1)) ? '0 : w_win + 1'b1;

    // ------------------------------------------------------------------------
    // Sequential: pointer and broadcast register. Without a grant only the
    // valid bit drops; tag/data/src keep their last values.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_cdb_src   <= '0;
        end else begin
            r_cdb_valid <= w_grant;
            if (w_grant) begin
                r_ptr      <= w_ptr_next;
                r_cdb_tag  <= w_tag_arr[w_win];
                r_cdb_data <= w_data_arr[w_win];
                r_cdb_src  <= w_win;
            end
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;
    assign cdb_src   = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter: directed scenarios followed by a long
// randomized run, all compared against a behavioural model of the round-robin
// grant and the one-cycle-delayed broadcast.
// ============================================================================
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int RW = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N*RW-1:0]      req_tag;
    logic [N*DW-1:0]      req_data;
    logic                 cdb_valid;
    logic [RW-1:0]        cdb_tag;
    logic [DW-1:0]        cdb_data;
    logic [SW-1:0]        cdb_src;

    // per-unit stimulus
    logic [RW-1:0] tg [N];
    logic [DW-1:0] dt [N];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_tag[i*RW +: RW]  = tg[i];
            req_data[i*DW +: DW] = dt[i];
        end
    end

    cdb_arbiter #(.N_UNITS(N), .ROB_WIDTH(RW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    int            m_ptr;
    bit            e_valid;
    logic [RW-1:0] e_tag;
    logic [DW-1:0] e_data;
    int            e_src;
    int            last_grant;      // model winner of the cycle just simulated
    logic [N-1:0]  obs_ready;       // req_ready as seen in that cycle
    int            wait_cnt [N];    // grants to others while unit i waited

    // One clock cycle: check mid-cycle, advance the model, step past the edge.
    task automatic run_cycle();
        int w;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        w = -1;
        if (!reset && !flush) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (req_valid[idx]) begin
                    w = idx;
                    break;
                end
            end
        end
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        obs_ready = req_ready;
        check_val("req_ready", 64'(req_ready), 64'(exp_ready));
        check_val("cdb_valid", 64'(cdb_valid), 64'(e_valid));
        check_val("cdb_tag",   64'(cdb_tag),   64'(e_tag));
        check_val("cdb_data",  64'(cdb_data),  64'(e_data));
        check_val("cdb_src",   64'(cdb_src),   64'(e_src));

        // fairness, measured on the DUT's own grants
        if (reset) begin
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else if (req_ready != '0) begin
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    check_val("fairness", 64'(wait_cnt[i] < N), 64'(1));
                    wait_cnt[i] = 0;
                end else if (req_valid[i]) begin
                    wait_cnt[i]++;
                end
            end
        end

        if (reset) begin
            m_ptr   = 0;
            e_valid = 0;
            e_tag   = '0;
            e_data  = '0;
            e_src   = 0;
        end else if (w >= 0) begin
            m_ptr   = (w + 1) % N;
            e_valid = 1;
            e_tag   = tg[w];
            e_data  = dt[w];
            e_src   = w;
        end else begin
            e_valid = 0;
        end
        last_grant = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) run_cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            tg[i] = '0;
            dt[i] = '0;
            wait_cnt[i] = 0;
        end
        m_ptr = 0; e_valid = 0; e_tag = '0; e_data = '0; e_src = 0;
        last_grant = -1;
        @(posedge clk);
        #1;
        do_reset(2);
        check_val("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        check_val("rst_cdb_src",   64'(cdb_src),   64'(0));

        // ---- single request on unit 1 ----
        req_valid = 4'b0010; tg[1] = 4'd5; dt[1] = 32'hDEADBEEF;
        run_cycle();
        check_val("t1_ready", 64'(obs_ready), 64'(4'b0010));
        check_val("t1_valid", 64'(cdb_valid), 64'(1));
        check_val("t1_tag",   64'(cdb_tag),   64'(5));
        check_val("t1_data",  64'(cdb_data),  64'(32'hDEADBEEF));
        check_val("t1_src",   64'(cdb_src),   64'(1));
        req_valid = '0;
        run_cycle();
        check_val("t1_drop", 64'(cdb_valid), 64'(0));
        // ptr should now be 2: all-valid grants unit 2
        req_valid = 4'b1111;
        run_cycle();
        check_val("t1_ptr", 64'(obs_ready), 64'(4'b0100));
        req_valid = '0;

        // ---- all four valid from ptr=0, rotating grants ----
        do_reset(1);
        for (int i = 0; i < N; i++) tg[i] = RW'(i);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [N-1:0] exp_oh;
            exp_oh = '0;
            exp_oh[k % N] = 1'b1;
            run_cycle();
            check_val("rr_grant", 64'(obs_ready), 64'(exp_oh));
            check_val("rr_tag",   64'(cdb_tag),   64'(k % N));
            check_val("rr_bus",   64'(cdb_valid), 64'(1));
        end
        req_valid = '0;
        run_cycle();

        // ---- wrap: ptr=3 with units 3 and 0 valid ----
        // ptr is 1 now; a lone grant to unit 2 moves it to 3
        req_valid = 4'b0100;
        run_cycle();
        req_valid = 4'b1001;
        run_cycle();
        check_val("wrap_first", 64'(obs_ready), 64'(4'b1000));
        req_valid[3] = 1'b0;
        run_cycle();
        check_val("wrap_second", 64'(obs_ready), 64'(4'b0001));
        req_valid = 4'b1111;
        run_cycle();
        check_val("wrap_ptr1", 64'(obs_ready), 64'(4'b0010));
        req_valid = '0;
        run_cycle();

        // ---- flush holds off unit 2 ----
        req_valid = 4'b0100; tg[2] = 4'd7;
        flush = 1'b1;
        for (int k = 0; k < 2; k++) begin
            run_cycle();
            check_val("flush_ready", 64'(obs_ready), 64'(0));
            check_val("flush_bus",   64'(cdb_valid), 64'(0));
        end
        flush = 1'b0;
        run_cycle();
        check_val("flush_after", 64'(obs_ready), 64'(4'b0100));
        check_val("flush_tag",   64'(cdb_tag),   64'(7));
        req_valid = '0;

        // ---- reset right after a grant ----
        do_reset(1);
        req_valid = 4'b0011;
        run_cycle();
        check_val("rst_grant0", 64'(obs_ready), 64'(4'b0001));
        req_valid[0] = 1'b0;
        reset = 1'b1;
        run_cycle();
        check_val("rst_mid_ready", 64'(obs_ready), 64'(0));
        check_val("rst_mid_bus",   64'(cdb_valid), 64'(0));
        reset = 1'b0;
        run_cycle();
        check_val("rst_regrant", 64'(obs_ready), 64'(4'b0010));
        req_valid = '0;
        run_cycle();

        // ---- randomized traffic ----
        for (int c = 0; c < 10000; c++) begin
            if (last_grant >= 0) req_valid[last_grant] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 3 == 0)) begin
                    req_valid[i] = 1'b1;
                    tg[i] = RW'($urandom);
                    dt[i] = $urandom;
                end
            end
            flush = ($urandom % 16 == 0);
            reset = ($urandom % 400 == 0);
            run_cycle();
        end
        flush = 1'b0;
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
